change_dispenser: RTL and testbench

Downstream stage of `candy_control`. It consumes the per-transaction `candy`, `change_beg` and `change_obeg` results and sequences the physical ejection motors one item at a time, confirming each drop with a sensor. It queues requests that arrive while it is busy, and retries or faults on a missed drop. Its motor outputs drive the machine's actuator drivers directly.

---
 rtl/change_dispenser.sv | 199 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
`timescale 1ns/1ps
// change_dispenser: queues candy/coin ejection requests and drives one ejector
// motor at a time, confirming each drop on a synchronized sensor edge.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | nothing in flight; start an item as soon as any count is nonzero
// S_DRIVE | latched motor on for PULSE_W cycles
// S_WAIT  | motor off, watching for a drop edge for up to TIMEOUT cycles
// S_GAP   | GAP_W quiet cycles after a confirmed drop, then next item or done
// S_FAULT | retries exhausted; motors off until clear_fault flushes the queue
module change_dispenser #(
  parameter int PULSE_W = 4,
  parameter int TIMEOUT = 64,
  parameter int GAP_W   = 2,
  parameter int RETRIES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       candy,
  input  logic [2:0] change_beg,
  input  logic       change_obeg,
  input  logic       drop_sense,
  input  logic       clear_fault,
  output logic       motor_candy,
  output logic       motor_beg,
  output logic       motor_obeg,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       overrun
);

  localparam int TMAX = (PULSE_W > TIMEOUT) ? ((PULSE_W > GAP_W) ? PULSE_W : GAP_W)
                                            : ((TIMEOUT > GAP_W) ? TIMEOUT : GAP_W);
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam int AW   = (RETRIES < 2) ? 1 : $clog2(RETRIES + 1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_GAP, S_FAULT} state_t;
  typedef enum logic [1:0] {T_CANDY, T_BEG, T_OBEG} item_t;

  state_t          state;
  item_t           item;
  item_t           next_item;
  logic [TW-1:0]   timer;
  logic [AW-1:0]   attempts;
  logic [2:0]      pend_candy;
  logic [4:0]      pend_beg;
  logic [2:0]      pend_obeg;
  logic [5:0]      sum_candy, sum_beg, sum_obeg;
  logic            ovf;
  logic            any_pend;
  logic            dec_candy, dec_beg, dec_obeg;
  logic            flush;
  logic            sync_1, sync_2, sync_3;
  logic            drop_edge;

  // one-hot motor pattern {candy, beg, obeg} for an item type
  function automatic logic [2:0] motor_sel(input item_t it);
    case (it)
      T_CANDY: motor_sel = 3'b100;
      T_BEG:   motor_sel = 3'b010;
      T_OBEG:  motor_sel = 3'b001;
      default: motor_sel = 3'b000;
    endcase
  endfunction

  // sensor synchronizer plus one extra stage for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
    end else begin
      sync_1 <= drop_sense;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  assign drop_edge = sync_2 & ~sync_3;
  assign any_pend  = (pend_candy != '0) | (pend_beg != '0) | (pend_obeg != '0);
  assign busy      = any_pend | (state != S_IDLE);
  assign flush     = (state == S_FAULT) & clear_fault;

  // confirmed drops decrement only the latched type, never below zero
  always_comb begin
    dec_candy = (state == S_WAIT) & drop_edge & (item == T_CANDY) & (pend_candy != '0);
    dec_beg   = (state == S_WAIT) & drop_edge & (item == T_BEG)   & (pend_beg   != '0);
    dec_obeg  = (state == S_WAIT) & drop_edge & (item == T_OBEG)  & (pend_obeg  != '0);
    sum_candy = 6'(pend_candy) + 6'(candy)       - 6'(dec_candy);
    sum_beg   = 6'(pend_beg)   + 6'(change_beg)  - 6'(dec_beg);
    sum_obeg  = 6'(pend_obeg)  + 6'(change_obeg) - 6'(dec_obeg);
    ovf       = (sum_candy > 6'd7) | (sum_beg > 6'd31) | (sum_obeg > 6'd7);
  end

  // priority selection of the next item to eject
  always_comb begin
    if (pend_candy != '0)    next_item = T_CANDY;
    else if (pend_beg != '0) next_item = T_BEG;
    else                     next_item = T_OBEG;
  end

  // pending counters with saturation and sticky overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_candy <= '0;
      pend_beg   <= '0;
      pend_obeg  <= '0;
      overrun    <= 1'b0;
    end else if (flush) begin
      pend_candy <= '0;
      pend_beg   <= '0;
      pend_obeg  <= '0;
    end else begin
      pend_candy <= (sum_candy > 6'd7)  ? 3'd7  : sum_candy[2:0];
      pend_beg   <= (sum_beg   > 6'd31) ? 5'd31 : sum_beg[4:0];
      pend_obeg  <= (sum_obeg  > 6'd7)  ? 3'd7  : sum_obeg[2:0];
      overrun    <= overrun | ovf;
    end
  end

  // sequencing FSM with registered motor, done and fault outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      item        <= T_CANDY;
      timer       <= '0;
      attempts    <= '0;
      motor_candy <= 1'b0;
      motor_beg   <= 1'b0;
      motor_obeg  <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_pend) begin
            item     <= next_item;
            attempts <= '0;
            timer    <= TW'(PULSE_W - 1);
            {motor_candy, motor_beg, motor_obeg} <= motor_sel(next_item);
            state    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (timer == '0) begin
            {motor_candy, motor_beg, motor_obeg} <= 3'b000;
            timer <= TW'(TIMEOUT - 1);
            state <= S_WAIT;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_WAIT: begin
          if (drop_edge) begin
            timer <= TW'(GAP_W - 1);
            state <= S_GAP;
          end else if (timer == '0) begin
            if (attempts == AW'(RETRIES)) begin
              fault <= 1'b1;
              state <= S_FAULT;
            end else begin
              attempts <= attempts + AW'(1);
              timer    <= TW'(PULSE_W - 1);
              {motor_candy, motor_beg, motor_obeg} <= motor_sel(item);
              state    <= S_DRIVE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_GAP: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else if (any_pend) begin
            item     <= next_item;
            attempts <= '0;
            timer    <= TW'(PULSE_W - 1);
            {motor_candy, motor_beg, motor_obeg} <= motor_sel(next_item);
            state    <= S_DRIVE;
          end else begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_FAULT: begin
          if (clear_fault) begin
            fault <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int PULSE_W = 4;
  localparam int TIMEOUT = 64;
  localparam int GAP_W   = 2;
  localparam int RETRIES = 2;

  logic       clk, reset, candy, change_obeg, drop_sense, clear_fault;
  logic [2:0] change_beg;
  logic       motor_candy, motor_beg, motor_obeg, busy, done, fault, overrun;

  change_dispenser #(.PULSE_W(PULSE_W), .TIMEOUT(TIMEOUT), .GAP_W(GAP_W), .RETRIES(RETRIES)) dut (
    .clk(clk), .reset(reset), .candy(candy), .change_beg(change_beg),
    .change_obeg(change_obeg), .drop_sense(drop_sense), .clear_fault(clear_fault),
    .motor_candy(motor_candy), .motor_beg(motor_beg), .motor_obeg(motor_obeg),
    .busy(busy), .done(done), .fault(fault), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed motor pulses: kind 0=candy 1=beg 2=obeg
  typedef struct { int kind; int start; int len; } pulse_t;
  pulse_t pq[$];
  int     done_q[$];
  int     done_busy_q[$];
  int     onehot_viol = 0;
  logic [2:0] prev_mv = 3'b000;
  int     cur_kind = 0, cur_start = 0;

  always @(negedge clk) begin
    logic [2:0] mv;
    mv = {motor_candy, motor_beg, motor_obeg};
    if ($countones(mv) > 1) onehot_viol++;
    if (mv != 3'b000 && prev_mv == 3'b000) begin
      cur_kind  = motor_candy ? 0 : (motor_beg ? 1 : 2);
      cur_start = cyc;
    end
    if (mv == 3'b000 && prev_mv != 3'b000) pq.push_back('{cur_kind, cur_start, cyc - cur_start});
    if (done) begin
      done_q.push_back(cyc);
      done_busy_q.push_back(int'(busy));
    end
    prev_mv = mv;
  end

  int   checks = 0;
  int   errors = 0;
  int   dq[$];
  int   drop_at = -1;
  bit   auto_drop = 1'b0;
  logic prev_any = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one cycle: inputs default low, sensor responder pulses drop_sense a set delay after each motor fall
  task automatic step();
    logic mv;
    @(negedge clk);
    candy = 1'b0; change_beg = 3'd0; change_obeg = 1'b0; clear_fault = 1'b0; drop_sense = 1'b0;
    mv = motor_candy | motor_beg | motor_obeg;
    if (auto_drop && prev_any && !mv) drop_at = cyc + ((dq.size() > 0) ? dq.pop_front() : 3);
    if (auto_drop && cyc == drop_at) drop_sense = 1'b1;
    prev_any = mv;
  endtask

  task automatic clear_obs();
    pq.delete(); done_q.delete(); done_busy_q.delete(); dq.delete(); drop_at = -1;
  endtask

  // reference: items leave in priority order; each occupies pulse + drop delay + sync(3) + gap
  task automatic check_run(input string tag, input int t0, input int kinds[$], input int delays[$]);
    int s;
    s = t0 + 2;
    chk($sformatf("%s_npulse", tag), pq.size(), kinds.size());
    for (int i = 0; i < kinds.size(); i++) begin
      if (i < pq.size()) begin
        chk($sformatf("%s_kind%0d", tag, i),  pq[i].kind,  kinds[i]);
        chk($sformatf("%s_start%0d", tag, i), pq[i].start, s);
        chk($sformatf("%s_len%0d", tag, i),   pq[i].len,   PULSE_W);
      end
      s = s + PULSE_W + delays[i] + 3 + GAP_W;
    end
    chk($sformatf("%s_ndone", tag), done_q.size(), 1);
    if (done_q.size() > 0) begin
      chk($sformatf("%s_done_cyc", tag), done_q[0], s);
      chk($sformatf("%s_busy_at_done", tag), done_busy_q[0], 0);
    end
  endtask

  function automatic int budget(input int delays[$]);
    int b;
    b = 10;
    foreach (delays[i]) b += PULSE_W + delays[i] + 3 + GAP_W;
    return b;
  endfunction

  task automatic run_simple(input string tag, input int nc, input int nb, input int no, input int delays[$]);
    int kinds[$];
    int t0;
    kinds.delete();
    for (int i = 0; i < nc; i++) kinds.push_back(0);
    for (int i = 0; i < nb; i++) kinds.push_back(1);
    for (int i = 0; i < no; i++) kinds.push_back(2);
    clear_obs();
    dq = delays;
    auto_drop = 1'b1;
    step();
    t0 = cyc;
    candy = (nc != 0); change_beg = 3'(nb); change_obeg = (no != 0);
    step();
    chk({tag, "_busy_rise"}, int'(busy), 1);
    repeat (budget(delays)) step();
    check_run(tag, t0, kinds, delays);
    chk({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    int t0;
    int kinds[$];
    int dl[$];
    reset = 1'b0; candy = 1'b0; change_beg = 3'd0; change_obeg = 1'b0;
    drop_sense = 1'b0; clear_fault = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_motor_candy", int'(motor_candy), 0);
    chk("rst_motor_beg",   int'(motor_beg), 0);
    chk("rst_motor_obeg",  int'(motor_obeg), 0);
    chk("rst_busy",        int'(busy), 0);
    chk("rst_done",        int'(done), 0);
    chk("rst_fault",       int'(fault), 0);
    chk("rst_overrun",     int'(overrun), 0);
    reset = 1'b1;
    repeat (3) step();
    chk("post_rst_busy", int'(busy), 0);

    dl = {3};
    run_simple("single", 1, 0, 0, dl);
    dl = {1, 1, 1, 1, 1};
    run_simple("mixed", 1, 3, 1, dl);

    // queue while busy: 2 beg, then 5 more during the first DRIVE
    clear_obs();
    dl = {1, 2, 0, 4, 1, 1, 2};
    dq = dl;
    auto_drop = 1'b1;
    step();
    t0 = cyc;
    change_beg = 3'd2;
    repeat (3) step();
    change_beg = 3'd5;
    repeat (budget(dl)) step();
    kinds = {1, 1, 1, 1, 1, 1, 1};
    check_run("queue", t0, kinds, dl);

    // request lands in the same cycle the first drop is detected
    clear_obs();
    dl = {2, 2, 2};
    dq = dl;
    step();
    t0 = cyc;
    change_beg = 3'd2;
    repeat (10) step();
    change_beg = 3'd1;
    step();
    chk("addsub_pend_beg", int'(dut.pend_beg), 2);
    repeat (budget(dl)) step();
    kinds = {1, 1, 1};
    check_run("addsub", t0, kinds, dl);

    for (int r = 0; r < 4; r++) begin
      int nc, nb, no;
      nc = $urandom_range(0, 1);
      nb = $urandom_range(0, 7);
      no = $urandom_range(0, 1);
      if (nc + nb + no == 0) nb = 1;
      dl.delete();
      for (int i = 0; i < nc + nb + no; i++) dl.push_back($urandom_range(0, 30));
      run_simple($sformatf("rand%0d", r), nc, nb, no, dl);
    end

    // retries exhausted with no sensor response
    clear_obs();
    auto_drop = 1'b0;
    step();
    t0 = cyc;
    candy = 1'b1;
    repeat (205) step();
    chk("fault_early", int'(fault), 0);
    step();
    chk("fault_set", int'(fault), 1);
    chk("fault_motors", int'({motor_candy, motor_beg, motor_obeg}), 0);
    chk("fault_npulse", pq.size(), RETRIES + 1);
    for (int i = 0; i < pq.size() && i < RETRIES + 1; i++) begin
      chk($sformatf("fault_start%0d", i), pq[i].start, t0 + 2 + i * (PULSE_W + TIMEOUT));
      chk($sformatf("fault_kind%0d", i), pq[i].kind, 0);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      change_beg = 3'd7;
    end
    step();
    chk("sat_pend_beg", int'(dut.pend_beg), 31);
    chk("sat_overrun", int'(overrun), 1);
    chk("sat_busy", int'(busy), 1);
    drop_sense = 1'b1;
    repeat (4) step();
    chk("fault_drop_ignored", int'(dut.pend_candy), 1);
    chk("fault_hold", int'(fault), 1);
    clear_fault = 1'b1;
    step();
    chk("clear_fault", int'(fault), 0);
    chk("clear_busy", int'(busy), 0);
    chk("clear_pend_beg", int'(dut.pend_beg), 0);
    repeat (20) step();
    chk("clear_no_pulse", pq.size(), RETRIES + 1);
    chk("clear_no_done", done_q.size(), 0);
    chk("overrun_sticky", int'(overrun), 1);

    // reset mid-DRIVE
    clear_obs();
    step();
    candy = 1'b1;
    repeat (3) step();
    chk("mid_drive_motor", int'(motor_candy), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_motors", int'({motor_candy, motor_beg, motor_obeg}), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    chk("mid_rst_fault", int'(fault), 0);
    step();
    step();
    reset = 1'b1;
    step();
    clear_obs();
    repeat (30) step();
    chk("post_rst_no_pulse", pq.size(), 0);
    chk("post_rst_no_done", done_q.size(), 0);
    chk("post_rst_idle", int'(busy), 0);

    chk("one_hot_motors", onehot_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
